wb_cfg_master: RTL
==================

# wb_cfg_master

Wishbone classic single-transfer initiator that drives the PWM/timer register-file slave from an on-chip command source (test sequencer, CPU-less config FSM). It takes one command at a time over a valid/ready port and runs exactly one bus cycle. It waits for `i_wb_ack`, with an optional timeout watchdog, then returns one response over a valid/ready port. It sits on the `i_wb_clk` domain, directly upstream of the Wishbone slave interface of `pwm_timer`.

## Interface
Parameters:
- `ADR_W`, 16, address width.
- `DAT_W`, 16, data width.
- `TIMEOUT`, 16, max BUS-state cycles without ack before abort; legal range 1..65535.

Ports:
- `i_wb_clk`  in  1  system clock, rising edge.
- `i_wb_rst`  in  1  reset, asynchronous, active-high.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  command accepted when high with `i_cmd_valid`.
- `i_cmd_we`  in  1  1 = write, 0 = read.
- `i_cmd_adr`  in  ADR_W  target address.
- `i_cmd_data`  in  DAT_W  write data; ignored for reads.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  response consumed when high with `o_rsp_valid`.
- `o_rsp_data`  out  DAT_W  read data; 0 for writes and on error.
- `o_rsp_err`  out  1  1 = transfer aborted by timeout.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1  Wishbone cycle, strobe, write enable.
- `o_wb_adr`  out  ADR_W  Wishbone address.
- `o_wb_data`  out  DAT_W  Wishbone write data.
- `i_wb_ack`  in  1  slave acknowledge.
- `i_wb_data`  in  DAT_W  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP; all outputs are registered.
- IDLE:
  - `o_cmd_ready`=1.
  - On `i_cmd_valid & o_cmd_ready`: latch `we`/`adr`/`data` into `o_wb_we`/`o_wb_adr`/`o_wb_data`, set `o_wb_cyc`=`o_wb_stb`=1, clear the timeout counter, go to BUS.
- BUS:
  - `o_cmd_ready`=0; `cyc`/`stb`/`we`/`adr`/`data` are held stable.
  - `i_wb_ack` is sampled only in BUS.
  - On ack: `o_rsp_data` = `i_wb_data` if read, else 0. `o_rsp_err`=0. Drop `cyc`/`stb`, set `o_rsp_valid`=1, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ack: `o_rsp_err`=1, `o_rsp_data`=0, drop `cyc`/`stb`, `o_rsp_valid`=1, go to RESP.
- RESP:
  - `o_rsp_valid` held until `i_rsp_ready`. Then clear `o_rsp_valid` and go to IDLE.
  - No new command is accepted in RESP (`o_cmd_ready`=0).
- Ack outside BUS (stale or stuck ack) is ignored. It has no effect on state or outputs.
- Ack in the same cycle as the timeout limit: ack wins, `o_rsp_err`=0.
- `o_wb_we`/`o_wb_adr`/`o_wb_data` keep their last values after the cycle ends; only `cyc`/`stb` return to 0.
- Counter width: `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Timing
- Reset values: `o_cmd_ready`=0 during reset and 1 from the first edge after release. All other outputs 0. State = IDLE.
- Command accepted at edge N: `cyc`/`stb` are high from N to the edge that samples ack.
- Ack sampled at edge N+k (k≥1): `cyc`/`stb` are low and `o_rsp_valid` is high after that edge. Minimum command-to-response is 2 edges.
- Timeout: BUS lasts exactly TIMEOUT cycles, then `o_rsp_valid` rises.
- Back-to-back: one idle cycle between a response handshake and the next command acceptance. Maximum throughput is 1 transfer per 3 cycles with zero-wait ack.
- Reset asserted mid-BUS or mid-RESP: all outputs go to 0 immediately and asynchronously. The in-flight command and response are discarded; no response is ever produced for them.

## Configuration
- `WB_CFG_MASTER_TIMEOUT_EN` defined: the timeout counter and abort path are present, as described above.
- Not defined: no counter. BUS waits indefinitely for ack, `o_rsp_err` is tied 0, and the `TIMEOUT` parameter is unused.

## Structure
- Shared package `wb_cfg_pkg` holds:
  - the state enum (IDLE/BUS/RESP);
  - the `ADR_W`/`DAT_W` defaults;
  - the register offsets CTRL=0x0, DIVISOR=0x2, PERIOD=0x4, DC=0x6;
  - the ctrl bit positions (ext_clk 0, pwm_mode 1, cnt_en 2, cont 3, out_en 4, irq_clr 5, duty_sel 6, sw_rst 7).
- One sub-module, `wb_timeout_cnt`: clear, enable, and `expired` flag at TIMEOUT-1. It is instantiated only under the macro.

## Test plan
- Write: `adr`=0x0000, `data`=0x0016; slave acks 1 cycle after `stb`. Expect `cyc`/`stb` high for 2 edges, `we`=1, `o_wb_data`=0x0016, then a response with `err`=0 and `data`=0x0000.
- Read: `adr`=0x0004; slave acks with `i_wb_data`=0xBEEF after 3 wait cycles. Expect `o_rsp_data`=0xBEEF and `err`=0.
- Timeout with `TIMEOUT`=16 and the macro on: a read that is never acked. Expect `cyc` high exactly 16 cycles, then `o_rsp_err`=1 and `o_rsp_data`=0. With the macro off, `cyc` stays high for 1000 cycles.
- Backpressure: hold `i_rsp_ready`=0 for 5 cycles with a new command pending. Expect `o_rsp_valid` and its data stable and `o_cmd_ready`=0 throughout. The next command is accepted 1 cycle after the handshake.
- Reset mid-BUS: assert `i_wb_rst` on cycle 2 of a transfer. Expect `cyc`/`stb`/`o_rsp_valid` to go to 0 in the same cycle and no response after release.
- Boundary cases:
  - ack on the timeout-limit cycle gives `err`=0;
  - an ack pulse while in IDLE causes no state change;
  - a stuck-high ack completes each transfer with k=1.

Source files
------------

// File: rtl/wb_cfg_pkg.sv
// wb_cfg_pkg: shared FSM state, bus width defaults and pwm_timer register map for the config master
package wb_cfg_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } wb_state_t;
  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;
  localparam logic [15:0] REG_CTRL    = 16'h0000;
  localparam logic [15:0] REG_DIVISOR = 16'h0002;
  localparam logic [15:0] REG_PERIOD  = 16'h0004;
  localparam logic [15:0] REG_DC      = 16'h0006;
  localparam int CTRL_EXT_CLK  = 0;
  localparam int CTRL_PWM_MODE = 1;
  localparam int CTRL_CNT_EN   = 2;
  localparam int CTRL_CONT     = 3;
  localparam int CTRL_OUT_EN   = 4;
  localparam int CTRL_IRQ_CLR  = 5;
  localparam int CTRL_DUTY_SEL = 6;
  localparam int CTRL_SW_RST   = 7;
  function automatic int cnt_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: saturating count of ack-less BUS cycles, flags the abort point at TIMEOUT-1
module wb_timeout_cnt
  import wb_cfg_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_wb_clk,
  input  logic i_wb_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CNT_W = cnt_width(TIMEOUT);
  logic [CNT_W-1:0] r_cnt;
  // restart on command accept, count each waiting BUS cycle, hold at all-ones instead of wrapping
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/wb_cfg_master.sv
// wb_cfg_master: single-transfer Wishbone classic initiator, one command in, one response out; WB_CFG_MASTER_TIMEOUT_EN adds the ack watchdog
module wb_cfg_master
  import wb_cfg_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = 16
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [ADR_W-1:0] i_cmd_adr,
  input  logic [DAT_W-1:0] i_cmd_data,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [DAT_W-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [ADR_W-1:0] o_wb_adr,
  output logic [DAT_W-1:0] o_wb_data,
  input  logic             i_wb_ack,
  input  logic [DAT_W-1:0] i_wb_data
);
  wb_state_t        r_state;
  logic             r_cmd_ready, r_rsp_valid, r_rsp_err, r_cyc, r_stb, r_we;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_data, r_rsp_data;
  logic             w_accept, w_expired;
  assign w_accept = (r_state == ST_IDLE) & i_cmd_valid & r_cmd_ready;
`ifdef WB_CFG_MASTER_TIMEOUT_EN
  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_wb_clk (i_wb_clk),
    .i_wb_rst (i_wb_rst),
    .i_clr    (w_accept),
    .i_en     ((r_state == ST_BUS) & ~i_wb_ack),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  // transfer FSM: ack only matters in BUS and beats a simultaneous timeout; we/adr/data persist after the cycle
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_data      <= '0;
    end else
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= ~w_accept;
          if (w_accept) begin
            r_we    <= i_cmd_we;
            r_adr   <= i_cmd_adr;
            r_data  <= i_cmd_data;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= ST_BUS;
          end
        end
        ST_BUS:
          if (i_wb_ack || w_expired) begin
            r_rsp_data  <= (i_wb_ack && !r_we) ? i_wb_data : '0;
            r_rsp_err   <= ~i_wb_ack;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        ST_RESP:
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_adr    = r_adr;
  assign o_wb_data   = r_data;
endmodule
